if_fetch_stage: RTL

//  Instruction-fetch stage and IF/ID pipeline register: the producer for the decode stage.

---
 rtl/if_fetch_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch + IF/ID register; one imem request outstanding, IF/ID updates 1 cycle after ack.
// Backpressure: freeze holds IF/ID (word parked in hold_q), branch_taken flushes; optional IF_PERF_CNT_EN counters.
// Latency: zero-wait memory sustains one instruction per cycle.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_address,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_instruction,
`ifdef IF_PERF_CNT_EN
    output logic             id_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
`else
    output logic             id_valid
`endif
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] seq_pc;
    logic [31:0] load_pc, load_ins;
    logic        do_bubble, do_load;
    logic [31:0] id_pc_d, id_ins_d;
    logic        id_vld_d;

    assign imem_req  = ((state_q == FETCH) || (state_q == DROP)) && rst;
    assign imem_addr = addr_q;
    assign seq_pc    = addr_q + PC_INC;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        do_bubble = 1'b0;
        do_load   = 1'b0;
        load_pc   = seq_pc;
        load_ins  = imem_rdata;
        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    do_bubble = 1'b1;
                    pc_d      = branch_address;
                    // An unacked request must still complete; DROP discards its word.
                    if (imem_ack) addr_d  = branch_address;
                    else          state_d = DROP;
                end else if (imem_ack) begin
                    pc_d = seq_pc;
                    if (freeze) begin
                        hold_d  = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        addr_d  = seq_pc;
                        do_load = 1'b1;
                    end
                end else if (!freeze) begin
                    do_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    do_bubble = 1'b1;
                    pc_d      = branch_address;
                    addr_d    = branch_address;
                    state_d   = FETCH;
                end else if (!freeze) begin
                    do_load  = 1'b1;
                    load_pc  = pc_q;
                    load_ins = hold_q;
                    addr_d   = pc_q;
                    state_d  = FETCH;
                end
            end
            DROP: begin
                if (branch_taken) begin
                    do_bubble = 1'b1;
                    pc_d      = branch_address;
                    if (imem_ack) begin
                        addr_d  = branch_address;
                        state_d = FETCH;
                    end
                end else begin
                    do_bubble = !freeze;
                    if (imem_ack) begin
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = FETCH;
        endcase

        id_pc_d  = id_pc;
        id_ins_d = id_instruction;
        id_vld_d = id_valid;
        if (do_bubble) begin
            id_pc_d  = 32'd0;
            id_ins_d = 32'd0;
            id_vld_d = 1'b0;
        end else if (do_load) begin
            id_pc_d  = load_pc;
            id_ins_d = load_ins;
            id_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            addr_q         <= RESET_PC;
            hold_q         <= 32'd0;
            id_pc          <= 32'd0;
            id_instruction <= 32'd0;
            id_valid       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            addr_q         <= addr_d;
            hold_q         <= hold_d;
            id_pc          <= id_pc_d;
            id_instruction <= id_ins_d;
            id_valid       <= id_vld_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (do_load && !(&fetch_count)) fetch_count <= fetch_count + 1'b1;
            if (freeze && !(&stall_count))  stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule
